// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Brief    : Single-direction traffic light: 1 s prescaler, GREEN/YELLOW/RED
//            phase FSM with BCD countdown, and a flashing-yellow night mode.
// Revision : 1.0 - initial release
// ============================================================================

module traffic_light_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int GREEN_TIME  = 25,
    parameter int YELLOW_TIME = 3,
    parameter int RED_TIME    = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       nightMode,
    output logic [2:0] ledSingle,
    output logic [3:0] controlLed7Seg1,
    output logic [3:0] controlLed7Seg0,
    output logic       phaseDone
);

    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    localparam logic [3:0] GREEN_TENS   = 4'(GREEN_TIME / 10);
    localparam logic [3:0] GREEN_UNITS  = 4'(GREEN_TIME % 10);
    localparam logic [3:0] YELLOW_TENS  = 4'(YELLOW_TIME / 10);
    localparam logic [3:0] YELLOW_UNITS = 4'(YELLOW_TIME % 10);
    localparam logic [3:0] RED_TENS     = 4'(RED_TIME / 10);
    localparam logic [3:0] RED_UNITS    = 4'(RED_TIME % 10);

    localparam logic [2:0] LED_GREEN  = 3'b100;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b001;
    localparam logic [2:0] LED_OFF    = 3'b000;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_RED    = 2'd2,
        ST_NIGHT  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          flash;
    logic          tick;
    logic          last_second;

    assign tick        = (presc == TICK_LAST);
    assign last_second = (controlLed7Seg1 == 4'd0) && (controlLed7Seg0 == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_RED;
            presc           <= '0;
            flash           <= 1'b0;
            ledSingle       <= LED_RED;
            controlLed7Seg1 <= RED_TENS;
            controlLed7Seg0 <= RED_UNITS;
            phaseDone       <= 1'b0;
        end else begin
            // phaseDone is a strobe, so it drops even while the rest is frozen
            phaseDone <= 1'b0;
            if (enable) begin
                if (state != ST_NIGHT && nightMode) begin
                    state           <= ST_NIGHT;
                    presc           <= '0;
                    flash           <= 1'b1;
                    ledSingle       <= LED_YELLOW;
                    controlLed7Seg1 <= 4'd0;
                    controlLed7Seg0 <= 4'd0;
                end else if (state == ST_NIGHT && !nightMode) begin
                    state           <= ST_RED;
                    presc           <= '0;
                    flash           <= 1'b0;
                    ledSingle       <= LED_RED;
                    controlLed7Seg1 <= RED_TENS;
                    controlLed7Seg0 <= RED_UNITS;
                end else begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        if (state == ST_NIGHT) begin
                            flash     <= ~flash;
                            ledSingle <= flash ? LED_OFF : LED_YELLOW;
                        end else if (last_second) begin
                            phaseDone <= 1'b1;
                            case (state)
                                ST_GREEN: begin
                                    state           <= ST_YELLOW;
                                    ledSingle       <= LED_YELLOW;
                                    controlLed7Seg1 <= YELLOW_TENS;
                                    controlLed7Seg0 <= YELLOW_UNITS;
                                end
                                ST_YELLOW: begin
                                    state           <= ST_RED;
                                    ledSingle       <= LED_RED;
                                    controlLed7Seg1 <= RED_TENS;
                                    controlLed7Seg0 <= RED_UNITS;
                                end
                                default: begin
                                    state           <= ST_GREEN;
                                    ledSingle       <= LED_GREEN;
                                    controlLed7Seg1 <= GREEN_TENS;
                                    controlLed7Seg0 <= GREEN_UNITS;
                                end
                            endcase
                        end else if (controlLed7Seg0 == 4'd0) begin
                            controlLed7Seg0 <= 4'd9;
                            controlLed7Seg1 <= controlLed7Seg1 - 4'd1;
                        end else begin
                            controlLed7Seg0 <= controlLed7Seg0 - 4'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
